// File: rtl/cpu_lsu.sv
`default_nettype none
// cpu_lsu: load/store unit driving a req/gnt/rvalid data-memory port, with alignment faults
// and sign/zero-extended load results. Revision 1.0
module cpu_lsu #(
  parameter int p_rd_buf = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en_mem,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_dmem_req,
  input  logic        i_dmem_gnt,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_we,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wr_data,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rd_data,
  output logic [31:0] o_rd_data,
  output logic        o_mem_done,
  output logic        o_misaligned,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RBUF  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_data_q;

  logic        misaligned_in;
  logic        accept;
  logic        rvalid_hit;
  logic        load_capture;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] ext_src;
  logic [15:0] shifted;
  logic [31:0] ext_data;

  always_comb begin
    misaligned_in = 1'b0;
    case (i_size)
      2'b01:   misaligned_in = i_addr[0];
      2'b10:   misaligned_in = |i_addr[1:0];
      2'b11:   misaligned_in = 1'b1;
      default: misaligned_in = 1'b0;
    endcase
  end

  // Lane enables and replicated store data are formed once, at acceptance.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = i_wr_data;
    case (i_size)
      2'b00: begin
        be_in    = 4'b0001 << i_addr[1:0];
        wdata_in = {4{i_wr_data[7:0]}};
      end
      2'b01: begin
        be_in    = 4'b0011 << {i_addr[1], 1'b0};
        wdata_in = {2{i_wr_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = i_wr_data;
      end
    endcase
  end

  assign accept     = (state == S_IDLE) && i_en_mem && !misaligned_in;
  assign rvalid_hit = (state == S_WAIT) && i_dmem_rvalid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_en_mem) begin
          state_nxt = misaligned_in ? S_FAULT : S_REQ;
        end
      end
      S_REQ: begin
        if (i_dmem_gnt) begin
          state_nxt = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_dmem_rvalid) begin
          state_nxt = (p_rd_buf != 0) ? S_RBUF : S_DONE;
        end
      end
      S_RBUF:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  generate
    if (p_rd_buf != 0) begin : g_rbuf
      logic [31:0] rbuf_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          rbuf_q <= 32'd0;
        end else if (rvalid_hit) begin
          rbuf_q <= i_dmem_rd_data;
        end
      end
      assign ext_src      = rbuf_q;
      assign load_capture = (state == S_RBUF);
    end else begin : g_no_rbuf
      assign ext_src      = i_dmem_rd_data;
      assign load_capture = rvalid_hit;
    end
  endgenerate

  assign shifted = 16'(ext_src >> {addr_q[1:0], 3'b000});

  always_comb begin
    ext_data = ext_src;
    case (size_q)
      2'b00:   ext_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   ext_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ext_data = ext_src;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= i_addr;
        we_q    <= i_we;
        size_q  <= i_size;
        uns_q   <= i_unsigned;
        be_q    <= be_in;
        wdata_q <= wdata_in;
      end
      if (load_capture) begin
        rd_data_q <= ext_data;
      end
    end
  end

  assign o_dmem_req     = (state == S_REQ);
  assign o_dmem_addr    = {addr_q[31:2], 2'b00};
  assign o_dmem_we      = o_dmem_req & we_q;
  assign o_dmem_be      = o_dmem_req ? be_q : 4'b0000;
  assign o_dmem_wr_data = wdata_q;
  assign o_rd_data      = rd_data_q;
  assign o_mem_done     = (state == S_DONE) || (state == S_FAULT);
  assign o_misaligned   = (state == S_FAULT);
  assign o_busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_lsu.sv
`default_nettype none
// tb_cpu_lsu: randomized and directed checks of cpu_lsu against a byte-level reference model.
// Revision 1.0
module tb_cpu_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // instance with direct read data
  logic        en_mem = 0, we = 0, uns = 0, dmem_gnt = 0, dmem_rvalid = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wr_data = 0, dmem_rd_data = 0;
  logic        dmem_req, dmem_we, mem_done, misaligned, busy;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wr_data, rd_data;

  // instance with buffered read data
  logic        b_en_mem = 0, b_we = 0, b_uns = 0, b_gnt = 0, b_rvalid = 0;
  logic [1:0]  b_size = 0;
  logic [31:0] b_addr = 0, b_wr_data = 0, b_mem_rd = 0;
  logic        b_req, b_dwe, b_done, b_mis, b_busy;
  logic [3:0]  b_be;
  logic [31:0] b_daddr, b_dwdata, b_rd_data;

  cpu_lsu #(.p_rd_buf(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en_mem(en_mem), .i_we(we), .i_size(size),
    .i_unsigned(uns), .i_addr(addr), .i_wr_data(wr_data),
    .o_dmem_req(dmem_req), .i_dmem_gnt(dmem_gnt), .o_dmem_addr(dmem_addr),
    .o_dmem_we(dmem_we), .o_dmem_be(dmem_be), .o_dmem_wr_data(dmem_wr_data),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rd_data(dmem_rd_data),
    .o_rd_data(rd_data), .o_mem_done(mem_done), .o_misaligned(misaligned), .o_busy(busy)
  );

  cpu_lsu #(.p_rd_buf(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en_mem(b_en_mem), .i_we(b_we), .i_size(b_size),
    .i_unsigned(b_uns), .i_addr(b_addr), .i_wr_data(b_wr_data),
    .o_dmem_req(b_req), .i_dmem_gnt(b_gnt), .o_dmem_addr(b_daddr),
    .o_dmem_we(b_dwe), .o_dmem_be(b_be), .o_dmem_wr_data(b_dwdata),
    .i_dmem_rvalid(b_rvalid), .i_dmem_rd_data(b_mem_rd),
    .o_rd_data(b_rd_data), .o_mem_done(b_done), .o_misaligned(b_mis), .o_busy(b_busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_rd = 0;
  logic [31:0] mdl_rd_b = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic exp_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] b;
    int n, off;
    b = 4'b0000;
    n = 1 << sz;
    off = int'(a % 4);
    for (int i = 0; i < n; i++) b[off + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] o;
    int n;
    n = 1 << sz;
    o = 0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = d[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int n, off;
    n = 1 << sz;
    off = int'(a % 4);
    v = 0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = w[8*(off + k) +: 8];
    if (!u && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // One access on the direct instance, checked cycle by cycle. Entered and left in IDLE.
  task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gw, input int rw, input logic [31:0] mw);
    logic flt;
    flt = exp_fault(sz, a);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", busy); end
    we = w; size = sz; uns = u; addr = a; wr_data = d; en_mem = 1'b1;
    dmem_gnt = 1'($urandom % 2); dmem_rvalid = 1'($urandom % 2); dmem_rd_data = $urandom;
    step();
    en_mem = 1'($urandom % 2); addr = $urandom; wr_data = $urandom;
    we = 1'($urandom % 2); size = 2'($urandom % 4); uns = 1'($urandom % 2);
    if (flt) begin
      checks++; if (mem_done !== 1'b1) begin errors++; $display("FAIL fault_done got %0b exp 1", mem_done); end
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL fault_mis got %0b exp 1", misaligned); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL fault_req got %0b exp 0", dmem_req); end
      checks++; if (rd_data !== mdl_rd) begin errors++; $display("FAIL fault_rd got %h exp %h", rd_data, mdl_rd); end
      step();
      checks++; if ({mem_done, misaligned, busy} !== 3'b000) begin
        errors++; $display("FAIL fault_after got %b exp 000", {mem_done, misaligned, busy}); end
      en_mem = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      return;
    end
    for (int g = 0; g <= gw; g++) begin
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL req got %0b exp 1", dmem_req); end
      checks++; if (dmem_addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL req_addr got %h exp %h", dmem_addr, {a[31:2], 2'b00}); end
      checks++; if (dmem_we !== w) begin errors++; $display("FAIL req_we got %0b exp %0b", dmem_we, w); end
      checks++; if (dmem_be !== exp_be(sz, a)) begin errors++; $display("FAIL req_be got %b exp %b", dmem_be, exp_be(sz, a)); end
      if (w) begin
        checks++; if (dmem_wr_data !== exp_wdata(sz, d)) begin errors++; $display("FAIL req_wdata got %h exp %h", dmem_wr_data, exp_wdata(sz, d)); end
      end
      checks++; if ({mem_done, busy} !== 2'b01) begin errors++; $display("FAIL req_status got %b exp 01", {mem_done, busy}); end
      dmem_gnt = (g == gw); dmem_rvalid = 1'($urandom % 2); en_mem = 1'($urandom % 2);
      step();
    end
    dmem_gnt = 1'b0;
    if (!w) begin
      for (int r = 0; r <= rw; r++) begin
        checks++; if ({dmem_req, dmem_we, dmem_be, mem_done, busy} !== 8'b0000_0001) begin
          errors++; $display("FAIL wait_status got %b exp 00000001", {dmem_req, dmem_we, dmem_be, mem_done, busy}); end
        dmem_gnt = 1'($urandom % 2); dmem_rvalid = (r == rw);
        dmem_rd_data = (r == rw) ? mw : $urandom;
        step();
      end
      dmem_rvalid = 1'b0;
      mdl_rd = exp_load(sz, u, a, mw);
    end
    checks++; if ({mem_done, misaligned, busy} !== 3'b101) begin errors++; $display("FAIL done_status got %b exp 101", {mem_done, misaligned, busy}); end
    checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'd0) begin errors++; $display("FAIL done_port got %b exp 0", {dmem_req, dmem_we, dmem_be}); end
    checks++; if (rd_data !== mdl_rd) begin errors++; $display("FAIL done_rd got %h exp %h", rd_data, mdl_rd); end
    dmem_rvalid = 1'($urandom % 2); dmem_gnt = 1'($urandom % 2); dmem_rd_data = $urandom; en_mem = 1'($urandom % 2);
    step();
    checks++; if ({mem_done, busy, dmem_req} !== 3'b000) begin errors++; $display("FAIL after_done got %b exp 000", {mem_done, busy, dmem_req}); end
    checks++; if (rd_data !== mdl_rd) begin errors++; $display("FAIL hold_rd got %h exp %h", rd_data, mdl_rd); end
    en_mem = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  // One load on the buffered instance: rvalid after rw wait cycles, done one cycle later than direct.
  task automatic run_load_b(input logic [1:0] sz, input logic u, input logic [31:0] a,
                            input logic [31:0] mw, input int rw);
    b_we = 1'b0; b_size = sz; b_uns = u; b_addr = a; b_en_mem = 1'b1;
    step();
    b_en_mem = 1'b0; b_addr = $urandom;
    checks++; if (b_req !== 1'b1) begin errors++; $display("FAIL b_req got %0b exp 1", b_req); end
    b_gnt = 1'b1;
    step();
    b_gnt = 1'b0;
    for (int r = 0; r <= rw; r++) begin
      checks++; if ({b_req, b_done} !== 2'b00) begin errors++; $display("FAIL b_wait got %b exp 00", {b_req, b_done}); end
      b_rvalid = (r == rw); b_mem_rd = (r == rw) ? mw : $urandom;
      step();
    end
    b_rvalid = 1'b0; b_mem_rd = $urandom;
    checks++; if ({b_done, b_busy} !== 2'b01) begin errors++; $display("FAIL b_rbuf got %b exp 01", {b_done, b_busy}); end
    checks++; if (b_rd_data !== mdl_rd_b) begin errors++; $display("FAIL b_rbuf_rd got %h exp %h", b_rd_data, mdl_rd_b); end
    step();
    mdl_rd_b = exp_load(sz, u, a, mw);
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b_done got %0b exp 1", b_done); end
    checks++; if (b_rd_data !== mdl_rd_b) begin errors++; $display("FAIL b_rd got %h exp %h", b_rd_data, mdl_rd_b); end
    step();
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b_idle got %0b exp 0", b_busy); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_be, mem_done, misaligned, busy} !== 9'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {dmem_req, dmem_we, dmem_be, mem_done, misaligned, busy}); end
    checks++; if ({dmem_addr, dmem_wr_data, rd_data} !== 96'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {dmem_addr, dmem_wr_data, rd_data}); end
    checks++; if ({b_req, b_busy, b_done, b_rd_data} !== 35'd0) begin
      errors++; $display("FAIL reset_b got %h exp 0", {b_req, b_busy, b_done, b_rd_data}); end
    en_mem = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_word_store();
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 0, 0, 32'h0);
  endtask

  task automatic test_byte_load();
    run_access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0, 0, 32'h80FF_7F01);
    checks++; if (rd_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h exp ffffff80", rd_data); end
    run_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 0, 0, 32'h80FF_7F01);
    checks++; if (rd_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd_data); end
  endtask

  task automatic test_half_store_stall();
    run_access(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_ABCD, 3, 0, 32'h0);
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 0, 32'h0);
    run_access(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 0, 32'h0);
    checks++; if (rd_data !== 32'h0000_0080) begin errors++; $display("FAIL mis_rd_hold got %h exp 00000080", rd_data); end
  endtask

  task automatic test_reset_mid();
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0, 32'hCAFE_F00D);
    we = 1'b0; size = 2'b10; addr = 32'h20; en_mem = 1'b1;
    step();
    en_mem = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({dmem_req, busy, mem_done} !== 3'b000) begin errors++; $display("FAIL async_rst got %b exp 000", {dmem_req, busy, mem_done}); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL async_rst_rd got %h exp 0", rd_data); end
    #2 rst = 1'b0;
    mdl_rd = 32'd0; mdl_rd_b = 32'd0;
    dmem_rvalid = 1'b1; dmem_rd_data = 32'hFFFF_FFFF;
    step();
    dmem_rvalid = 1'b0;
    checks++; if ({busy, mem_done} !== 2'b00) begin errors++; $display("FAIL stray_rvalid got %b exp 00", {busy, mem_done}); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL stray_rd got %h exp 0", rd_data); end
    step();
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom % 4);
      a  = $urandom;
      if (($urandom % 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      run_access(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom,
                 int'($urandom % 3), int'($urandom % 3), $urandom);
    end
  endtask

  task automatic test_rd_buf();
    run_load_b(2'b01, 1'b1, 32'h2, 32'h1234_8000, 0);
    checks++; if (b_rd_data !== 32'h0000_1234) begin errors++; $display("FAIL lhu_buf got %h exp 00001234", b_rd_data); end
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom % 3);
      a  = $urandom & ~((32'd1 << sz) - 32'd1);
      run_load_b(sz, 1'($urandom % 2), a, $urandom, int'($urandom % 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store_stall();
    test_misaligned();
    test_reset_mid();
    test_random();
    test_rd_buf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_lsu.md
# cpu_lsu

Load/store unit sitting directly downstream of the execute stage. It takes the effective address from the execute adder and the store data from register-file port 2. It then runs a request/grant/read-valid transaction on the data-memory port and returns an aligned, sign- or zero-extended load result to the write-back mux (`wb_dmem`). It flags misaligned or illegal-size accesses instead of issuing them, and provides a done pulse that gates the core's stage advance.

## Interface
Parameters:
- `p_rd_buf`, default 0: 1 registers `i_dmem_rd_data` before extraction, adding one cycle to load latency.

Ports:
- `i_clk`  in  1  global clock
- `i_rst`  in  1  global reset, asynchronous, active-high
- `i_en_mem`  in  1  start access; sampled only in IDLE
- `i_we`  in  1  1 = store, 0 = load
- `i_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `i_unsigned`  in  1  1 = zero-extend load (LBU/LHU)
- `i_addr`  in  32  effective address (execute adder output)
- `i_wr_data`  in  32  store data (rs2)
- `o_dmem_req`  out  1  memory request
- `i_dmem_gnt`  in  1  request accepted this cycle
- `o_dmem_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `o_dmem_we`  out  1  write enable
- `o_dmem_be`  out  4  byte enables
- `o_dmem_wr_data`  out  32  lane-replicated store data
- `i_dmem_rvalid`  in  1  read data valid
- `i_dmem_rd_data`  in  32  read data
- `o_rd_data`  out  32  extracted and extended load result
- `o_mem_done`  out  1  one-cycle completion pulse
- `o_misaligned`  out  1  one-cycle fault pulse, coincident with `o_mem_done`
- `o_busy`  out  1  state is not IDLE

## Operation
- **FSM states:** IDLE, REQ, WAIT, (RBUF when `p_rd_buf`=1), DONE, FAULT.
- **IDLE:**
  - `i_en_mem`=1 with a misaligned access goes to FAULT. Misaligned means half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11.
  - `i_en_mem`=1 with an aligned access latches addr, we, size, unsigned and wr_data, then goes to REQ.
  - `i_en_mem`=0 stays in IDLE.
- **REQ:**
  - `o_dmem_req`=1. addr, we, be and wr_data come from the latched values and stay stable until grant.
  - On `i_dmem_gnt`: a store goes to DONE; a load goes to WAIT.
  - Without grant, stay in REQ indefinitely.
- **WAIT:**
  - On `i_dmem_rvalid`: with `p_rd_buf`=0, capture the extracted result into `o_rd_data` and go to DONE. With `p_rd_buf`=1, register the raw data and go to RBUF.
- **RBUF:** capture the extracted result, then go to DONE.
- **DONE:** `o_mem_done`=1, then go to IDLE.
- **FAULT:** `o_mem_done`=1 and `o_misaligned`=1, then go to IDLE. No memory request is ever issued for a faulting access.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1],1'b0}`
  - word: `4'b1111`
  - `o_dmem_be`=0 and `o_dmem_we`=0 whenever `o_dmem_req`=0.
- **Store data:** byte `{4{d[7:0]}}`, half `{2{d[15:0]}}`, word `d`.
- **Load extraction:**
  - shifted = `rd_data >> (8*addr[1:0])`.
  - byte uses `shifted[7:0]`, half uses `shifted[15:0]`.
  - Bit 7 / bit 15 is replicated when `i_unsigned`=0; zeros are used when `i_unsigned`=1. Word is passed unchanged.
- **`o_rd_data` update rule:** it updates only on a completed load. It holds across stores, faults and idle.
- **Ignored inputs:**
  - `i_en_mem` when not in IDLE.
  - `i_dmem_rvalid` in IDLE or REQ, or during a store.
  - `i_dmem_gnt` outside REQ.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE. Reset is asynchronous, so asserting it mid-transaction drops `o_dmem_req` immediately with no done pulse. Any outstanding `rvalid` after reset is ignored.
- **Registered outputs:** `o_dmem_req` and the `o_dmem_*` signals are driven from registered state. They are not combinational from `i_en_mem`.
- **Latency with zero-wait memory** (gnt in the request cycle, rvalid one cycle after gnt), with `i_en_mem` in cycle 0:
  - store: req in cycle 1, done in cycle 2.
  - load, `p_rd_buf`=0: req in 1, rvalid in 2, done in 3, `o_rd_data` valid from cycle 3.
  - load, `p_rd_buf`=1: done in 4.
  - fault: done and misaligned in cycle 1.
- **Wait states:** each gnt or rvalid wait cycle adds exactly one cycle to the latency.
- **Back-to-back accesses:** the earliest next `i_en_mem` acceptance is the cycle after DONE/FAULT. Maximum throughput is one store per 3 cycles and one load per 4 cycles (`p_rd_buf`=0).
- **`o_busy` timing:** high from the cycle after acceptance through the DONE/FAULT cycle inclusive.

## Test plan
- **Word store:** `i_addr`=0x100, `i_wr_data`=0xDEADBEEF, size 10, gnt in the request cycle → cycle 1: req=1, addr=0x100, be=1111, wr_data=0xDEADBEEF; cycle 2: `o_mem_done`=1.
- **Byte load, signed then unsigned:** `i_addr`=0x203, mem returns 0x80FF7F01 → LB gives `o_rd_data`=0xFFFFFF80 at done (cycle 3); LBU at the same address gives 0x00000080.
- **Half store with grant stall:** `i_addr`=0x42, `i_wr_data`=0x0000ABCD, gnt withheld 3 cycles → req held for 4 cycles with be=1100, wr_data=0xABCDABCD stable throughout; done 1 cycle after gnt.
- **Misaligned:** word load at 0x101 and half load at 0x103 → each gives done=1 and misaligned=1 in cycle 1, req never asserted, `o_rd_data` unchanged.
- **Reset and ignored inputs:**
  - Load in WAIT, `i_rst` pulsed → req, busy and done all 0 immediately; a stray rvalid afterwards leaves state IDLE and `o_rd_data`=0.
  - `i_en_mem` pulsed while busy → no second transaction.
- **`p_rd_buf`=1:** LHU at 0x0002, mem returns 0x1234_8000 → `o_rd_data`=0x00001234, done in cycle 4.
